// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load/ADDZ-use stall generation for the 16-bit pipeline.
// Tracks EX/MEM/WB destination tags and registers per-source forward selects for the EX stage.
module fwd_hazard_unit #(
    parameter int REG_W    = 4,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hlt,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src0,
    input  logic [REG_W-1:0] id_src1,
    input  logic             id_src0_used,
    input  logic             id_src1_used,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_addz,
    input  logic             ex_reg_write_final,
    output logic             stall,
    output logic             cntrl_src0_fwd,
    output logic             cntrl_src1_fwd,
    output logic             cntrl_src0_memex_fwd,
    output logic             cntrl_src1_memex_fwd
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    // EX tag
    logic [REG_W-1:0] ex_dst_q, ex_dst_d;
    logic             ex_wr_q, ex_wr_d;
    logic             ex_load_q, ex_load_d;
    logic             ex_addz_q, ex_addz_d;
    // MEM and WB tags
    logic [REG_W-1:0] mem_dst_q, mem_dst_d;
    logic             mem_wr_q, mem_wr_d;
    logic [REG_W-1:0] wb_dst_q;
    logic             wb_wr_q;
    // Registered forward selects
    logic             src0_fwd_q, src0_fwd_d;
    logic             src1_fwd_q, src1_fwd_d;
    logic             src0_memex_q, src0_memex_d;
    logic             src1_memex_q, src1_memex_d;

    logic ex_match0, ex_match1, mem_match0, mem_match1;
    logic hazard, bubble;

    function automatic logic tag_match(
        input logic             wr,
        input logic [REG_W-1:0] dst,
        input logic [REG_W-1:0] src,
        input logic             used,
        input logic             valid
    );
        return wr && (dst == src) && (src != ZERO_IDX) && used && valid;
    endfunction

    always_comb begin
        ex_match0  = tag_match(ex_wr_q,  ex_dst_q,  id_src0, id_src0_used, id_valid);
        ex_match1  = tag_match(ex_wr_q,  ex_dst_q,  id_src1, id_src1_used, id_valid);
        mem_match0 = tag_match(mem_wr_q, mem_dst_q, id_src0, id_src0_used, id_valid);
        mem_match1 = tag_match(mem_wr_q, mem_dst_q, id_src1, id_src1_used, id_valid);

        // ADDZ in EX has an unresolved write, so it stalls its consumers like a load does
        hazard = (ex_match0 || ex_match1) && (ex_load_q || ex_addz_q);
        bubble = hazard || flush;

        mem_dst_d = ex_dst_q;
        mem_wr_d  = ex_reg_write_final;

        ex_dst_d  = id_dst;
        ex_wr_d   = 1'b0;
        ex_load_d = 1'b0;
        ex_addz_d = 1'b0;

        src0_fwd_d   = 1'b0;
        src0_memex_d = 1'b0;
        src1_fwd_d   = 1'b0;
        src1_memex_d = 1'b0;

        if (!bubble) begin
            ex_wr_d   = id_reg_write && id_valid;
            ex_load_d = id_mem_read && id_valid;
            ex_addz_d = id_addz && id_valid;

            // Youngest producer wins: EX tag is checked before MEM tag
            if (ex_match0) begin
                src0_fwd_d   = 1'b1;
                src0_memex_d = 1'b1;
            end else if (mem_match0) begin
                src0_fwd_d   = 1'b1;
            end

            if (ex_match1) begin
                src1_fwd_d   = 1'b1;
                src1_memex_d = 1'b1;
            end else if (mem_match1) begin
                src1_fwd_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_wr_q      <= 1'b0;
            ex_load_q    <= 1'b0;
            ex_addz_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            wb_wr_q      <= 1'b0;
            src0_fwd_q   <= 1'b0;
            src0_memex_q <= 1'b0;
            src1_fwd_q   <= 1'b0;
            src1_memex_q <= 1'b0;
        end else if (!hlt) begin
            ex_dst_q     <= ex_dst_d;
            ex_wr_q      <= ex_wr_d;
            ex_load_q    <= ex_load_d;
            ex_addz_q    <= ex_addz_d;
            mem_dst_q    <= mem_dst_d;
            mem_wr_q     <= mem_wr_d;
            wb_dst_q     <= mem_dst_q;
            wb_wr_q      <= mem_wr_q;
            src0_fwd_q   <= src0_fwd_d;
            src0_memex_q <= src0_memex_d;
            src1_fwd_q   <= src1_fwd_d;
            src1_memex_q <= src1_memex_d;
        end
    end

    // WB tag is kept only for debug visibility; the register file writes through
    logic unused_wb;
    assign unused_wb = ^{wb_dst_q, wb_wr_q};

    assign stall                = hazard;
    assign cntrl_src0_fwd       = src0_fwd_q;
    assign cntrl_src1_fwd       = src1_fwd_q;
    assign cntrl_src0_memex_fwd = src0_memex_q;
    assign cntrl_src1_memex_fwd = src1_memex_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed testbench for fwd_hazard_unit: forwarding distances, load/ADDZ-use stalls, flush and halt.
module tb_fwd_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic       hlt;
    logic       flush;
    logic       id_valid;
    logic [3:0] id_src0;
    logic [3:0] id_src1;
    logic       id_src0_used;
    logic       id_src1_used;
    logic [3:0] id_dst;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_addz;
    logic       ex_reg_write_final;
    logic       stall;
    logic       cntrl_src0_fwd;
    logic       cntrl_src1_fwd;
    logic       cntrl_src0_memex_fwd;
    logic       cntrl_src1_memex_fwd;

    int checks = 0;
    int errors = 0;
    logic [4:0] obs;

    fwd_hazard_unit #(.REG_W(4), .ZERO_REG(0)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .hlt                  (hlt),
        .flush                (flush),
        .id_valid             (id_valid),
        .id_src0              (id_src0),
        .id_src1              (id_src1),
        .id_src0_used         (id_src0_used),
        .id_src1_used         (id_src1_used),
        .id_dst               (id_dst),
        .id_reg_write         (id_reg_write),
        .id_mem_read          (id_mem_read),
        .id_addz              (id_addz),
        .ex_reg_write_final   (ex_reg_write_final),
        .stall                (stall),
        .cntrl_src0_fwd       (cntrl_src0_fwd),
        .cntrl_src1_fwd       (cntrl_src1_fwd),
        .cntrl_src0_memex_fwd (cntrl_src0_memex_fwd),
        .cntrl_src1_memex_fwd (cntrl_src1_memex_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // obs = {stall, src0_fwd, src0_memex, src1_fwd, src1_memex}
    always_comb obs = {stall, cntrl_src0_fwd, cntrl_src0_memex_fwd, cntrl_src1_fwd, cntrl_src1_memex_fwd};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s0, input logic u0,
                          input logic [3:0] s1, input logic u1, input logic [3:0] d,
                          input logic rw, input logic mr, input logic az);
        id_valid     = v;
        id_src0      = s0;
        id_src0_used = u0;
        id_src1      = s1;
        id_src1_used = u1;
        id_dst       = d;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_addz      = az;
        #1;
    endtask

    task automatic drain();
        flush = 1'b0;
        hlt = 1'b0;
        ex_reg_write_final = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hlt = 1'b0;
        repeat (2) begin
            flush = 1'($urandom);
            ex_reg_write_final = 1'($urandom);
            set_id(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                   4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step();
            checks++;
            if (obs !== 5'b00000) begin
                errors++;
                $display("FAIL reset_hold: got %b expected %b", obs, 5'b00000);
            end
        end
        rst_n = 1'b1;
        drain();
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", obs, 5'b00000);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0);    // ADD R3
        step();
        ex_reg_write_final = 1'b1;
        set_id(1, 4'd3, 1, 4'd7, 1, 4'd8, 1, 0, 0);    // SUB R8 <- R3, R7
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL b2b_id_stall: got %b expected %b", obs, 5'b00000);
        end
        step();
        checks++;
        if (obs !== 5'b01100) begin
            errors++;
            $display("FAIL b2b_ex_fwd: got %b expected %b", obs, 5'b01100);
        end
    endtask

    task automatic test_distance2();
        drain();
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd5, 1, 0, 0);    // ADD R5
        step();
        ex_reg_write_final = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);             // NOP
        step();
        ex_reg_write_final = 1'b0;
        set_id(1, 4'd1, 1, 4'd5, 1, 4'd6, 1, 0, 0);    // AND R6 <- R1, R5
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL dist2_id: got %b expected %b", obs, 5'b00000);
        end
        step();
        checks++;
        if (obs !== 5'b00010) begin
            errors++;
            $display("FAIL dist2_mem_fwd: got %b expected %b", obs, 5'b00010);
        end

        drain();
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd0, 1, 0, 0);    // ADD R0
        step();
        ex_reg_write_final = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        ex_reg_write_final = 1'b0;
        set_id(1, 4'd0, 1, 4'd0, 1, 4'd6, 1, 0, 0);    // reads R0 twice
        step();
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL dist2_r0: got %b expected %b", obs, 5'b00000);
        end

        drain();
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd0, 1, 0, 0);    // ADD R0 then immediate reader
        step();
        ex_reg_write_final = 1'b1;
        set_id(1, 4'd0, 1, 4'd0, 1, 4'd6, 1, 0, 0);
        step();
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL dist1_r0: got %b expected %b", obs, 5'b00000);
        end
    endtask

    task automatic test_load_use();
        drain();
        set_id(1, 4'd6, 1, 4'd0, 0, 4'd2, 1, 1, 0);    // LW R2
        step();
        ex_reg_write_final = 1'b1;
        set_id(1, 4'd2, 1, 4'd9, 1, 4'd10, 1, 0, 0);   // ADD R10 <- R2, R9
        checks++;
        if (obs !== 5'b10000) begin
            errors++;
            $display("FAIL lu_stall: got %b expected %b", obs, 5'b10000);
        end
        step();
        ex_reg_write_final = 1'b0;                     // bubble in EX
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL lu_bubble: got %b expected %b", obs, 5'b00000);
        end
        step();
        checks++;
        if (obs !== 5'b01000) begin
            errors++;
            $display("FAIL lu_mem_fwd: got %b expected %b", obs, 5'b01000);
        end
    endtask

    task automatic test_addz(input logic wr_final, input logic [4:0] exp_final);
        drain();
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd4, 1, 0, 1);    // ADDZ R4
        step();
        ex_reg_write_final = wr_final;
        set_id(1, 4'd3, 1, 4'd4, 1, 4'd11, 1, 0, 0);   // reader of R4 on src1
        checks++;
        if (obs !== 5'b10000) begin
            errors++;
            $display("FAIL addz_stall(wr=%0b): got %b expected %b", wr_final, obs, 5'b10000);
        end
        step();
        ex_reg_write_final = 1'b0;
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL addz_bubble(wr=%0b): got %b expected %b", wr_final, obs, 5'b00000);
        end
        step();
        checks++;
        if (obs !== exp_final) begin
            errors++;
            $display("FAIL addz_fwd(wr=%0b): got %b expected %b", wr_final, obs, exp_final);
        end
    endtask

    task automatic test_flush();
        drain();
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd7, 1, 0, 0);    // ADD R7
        step();
        ex_reg_write_final = 1'b1;
        flush = 1'b1;
        set_id(1, 4'd7, 1, 4'd7, 1, 4'd12, 1, 0, 0);   // dependent, squashed
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL flush_id: got %b expected %b", obs, 5'b00000);
        end
        step();
        flush = 1'b0;
        ex_reg_write_final = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL flush_sel: got %b expected %b", obs, 5'b00000);
        end

        drain();
        set_id(1, 4'd6, 1, 4'd0, 0, 4'd2, 1, 1, 0);    // LW R2, then flush + load-use together
        step();
        ex_reg_write_final = 1'b1;
        flush = 1'b1;
        set_id(1, 4'd2, 1, 4'd0, 0, 4'd13, 1, 0, 0);
        checks++;
        if (obs !== 5'b10000) begin
            errors++;
            $display("FAIL flush_stall_same: got %b expected %b", obs, 5'b10000);
        end
        step();
        flush = 1'b0;
        ex_reg_write_final = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL flush_stall_after: got %b expected %b", obs, 5'b00000);
        end
    endtask

    task automatic test_halt();
        drain();
        set_id(1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0);    // ADD R3
        step();
        ex_reg_write_final = 1'b1;
        set_id(1, 4'd3, 1, 4'd0, 0, 4'd8, 1, 0, 0);    // SUB R8 <- R3
        step();
        set_id(1, 4'd0, 0, 4'd8, 1, 4'd9, 1, 0, 0);    // OR R9 <- R8
        hlt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== 5'b01100) begin
                errors++;
                $display("FAIL halt_hold[%0d]: got %b expected %b", i, obs, 5'b01100);
            end
        end
        hlt = 1'b0;
        step();
        checks++;
        if (obs !== 5'b00011) begin
            errors++;
            $display("FAIL halt_resume: got %b expected %b", obs, 5'b00011);
        end

        drain();
        set_id(1, 4'd6, 1, 4'd0, 0, 4'd2, 1, 1, 0);    // LW R2, halt while hazard pending
        step();
        ex_reg_write_final = 1'b1;
        set_id(1, 4'd2, 1, 4'd0, 0, 4'd10, 1, 0, 0);
        hlt = 1'b1;
        repeat (2) step();
        checks++;
        if (obs !== 5'b10000) begin
            errors++;
            $display("FAIL halt_stall_hold: got %b expected %b", obs, 5'b10000);
        end
        hlt = 1'b0;
        step();
        ex_reg_write_final = 1'b0;
        checks++;
        if (obs !== 5'b00000) begin
            errors++;
            $display("FAIL halt_stall_bubble: got %b expected %b", obs, 5'b00000);
        end
        step();
        checks++;
        if (obs !== 5'b01000) begin
            errors++;
            $display("FAIL halt_stall_fwd: got %b expected %b", obs, 5'b01000);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        hlt = 1'b0;
        flush = 1'b0;
        ex_reg_write_final = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_addz(1'b0, 5'b00000);
        test_addz(1'b1, 5'b00010);
        test_flush();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
